// File: rtl/text_addr_gen_pkg.sv
// text_addr_gen_pkg: shared geometry defaults and FSM encoding for the text address generator
package text_addr_gen_pkg;
   localparam int CHAR_W_DEF = 8;
   localparam int CHAR_H_DEF = 16;
   localparam int COLS_DEF   = 80;
   localparam int ADDR_W_DEF = 13;
   typedef enum logic [1:0] {
      WAIT_VBL = 2'd0,
      ARMED    = 2'd1,
      ACTIVE   = 2'd2
   } state_t;
endpackage

// File: rtl/vid_delay_line.sv
// vid_delay_line: DEPTH x WIDTH shift register advanced on en
module vid_delay_line #(
   parameter int DEPTH = 1,
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] sr [DEPTH];
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
      end else if (en) begin
         sr[0] <= d;
         for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
   end
   assign q = sr[DEPTH-1];
endmodule

// File: rtl/text_addr_gen.sv
// text_addr_gen: text-mode char address / font row / pixel column generator with re-timed sync outputs
module text_addr_gen
   import text_addr_gen_pkg::*;
#(
   parameter int PIX_CLK_DIVIDED = 4,
   parameter int SAMPLE_PHASE    = 1,
   parameter int CHAR_W          = CHAR_W_DEF,
   parameter int CHAR_H          = CHAR_H_DEF,
   parameter int COLS            = COLS_DEF,
   parameter int BASE_ADDR       = 0,
   parameter int ADDR_W          = ADDR_W_DEF,
   parameter int SYNC_DELAY      = 2
) (
   input  logic                      pclk,
   input  logic                      reset,
   input  logic [3:0]                pc_ena,
   input  logic                      hde,
   input  logic                      vde,
   input  logic                      hsync,
   input  logic                      vsync,
   output logic                      pix_valid,
   output logic [ADDR_W-1:0]         char_addr,
   output logic [$clog2(CHAR_H)-1:0] font_row,
   output logic [$clog2(CHAR_W)-1:0] pix_col,
   output logic                      frame_start,
   output logic                      hde_o,
   output logic                      vde_o,
   output logic                      hsync_o,
   output logic                      vsync_o
);
   localparam int PW = $clog2(CHAR_W);
   localparam int RW = $clog2(CHAR_H);
   localparam int CW = $clog2(COLS);
   localparam logic [3:0] PHASE = 4'(SAMPLE_PHASE > PIX_CLK_DIVIDED ? PIX_CLK_DIVIDED : SAMPLE_PHASE);

   state_t            st, st_n;
   logic              s_ok, s_hde, s_vde, s_hs, s_vs, hde_q;
   logic [PW-1:0]     px;
   logic [CW-1:0]     col;
   logic [RW-1:0]     row;
   logic [ADDR_W-1:0] row_base;
   logic              strobe, enter, vis, eol;

   assign strobe = pc_ena == PHASE;

   // Inputs are captured on one strobe and acted on at the next, giving the one-strobe output latency.
   always_comb begin
      st_n  = !s_ok ? st : !s_vde ? ARMED : st == ARMED ? ACTIVE : st;
      enter = s_ok && s_vde && st == ARMED;
      vis   = s_ok && s_vde && s_hde && st != WAIT_VBL;
      eol   = s_ok && s_vde && !s_hde && hde_q && st == ACTIVE;
   end

   always_ff @(posedge pclk) begin
      if (reset) begin
         st          <= WAIT_VBL;
         {s_ok, s_hde, s_vde, s_hs, s_vs, hde_q} <= '0;
         px          <= '0;
         col         <= '0;
         row         <= '0;
         row_base    <= ADDR_W'(BASE_ADDR);
         pix_valid   <= 1'b0;
         char_addr   <= '0;
         font_row    <= '0;
         pix_col     <= '0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= strobe && enter && s_hde;
         if (strobe) begin
            {s_ok, s_hde, s_vde, s_hs, s_vs} <= {1'b1, hde, vde, hsync, vsync};
            st        <= st_n;
            hde_q     <= s_hde && s_vde;
            pix_valid <= vis;
            if (vis) begin
               char_addr <= row_base + ADDR_W'(col);
               font_row  <= row;
               pix_col   <= px;
            end
            if (!s_vde || st == WAIT_VBL) begin
               px       <= '0;
               col      <= '0;
               row      <= '0;
               row_base <= ADDR_W'(BASE_ADDR);
            end else if (vis) begin
               px <= px + PW'(1);
               // col saturates so an over-long line repeats its last cell instead of spilling into the next row
               if (px == PW'(CHAR_W - 1) && col != CW'(COLS - 1)) col <= col + CW'(1);
            end else if (eol) begin
               px  <= '0;
               col <= '0;
               row <= row + RW'(1);
               if (row == RW'(CHAR_H - 1)) row_base <= row_base + ADDR_W'(COLS);
            end
         end
      end
   end

   vid_delay_line #(.DEPTH(SYNC_DELAY + 1), .WIDTH(4)) u_dly (
      .clk (pclk),
      .rst (reset),
      .en  (strobe),
      .d   ({s_hde, s_vde, s_hs, s_vs}),
      .q   ({hde_o, vde_o, hsync_o, vsync_o})
   );
endmodule

// File: tb/tb_text_addr_gen.sv
// tb_text_addr_gen: scoreboard bench for text_addr_gen at default 640x480 text geometry
module tb_text_addr_gen;
   logic        pclk = 1'b0, reset = 1'b1;
   logic [3:0]  pc_ena = 4'd0;
   logic        hde = 1'b0, vde = 1'b0, hsync = 1'b0, vsync = 1'b0;
   logic        pix_valid, frame_start, hde_o, vde_o, hsync_o, vsync_o;
   logic [12:0] char_addr;
   logic [3:0]  font_row;
   logic [2:0]  pix_col;

   typedef struct {
      int          due;
      int          x;
      int          y;
      logic [12:0] addr;
      logic [3:0]  fr;
      logic [2:0]  pc;
      logic        fs;
   } exp_t;

   exp_t       q[$];
   logic [3:0] hist[$];
   int         n_chk = 0, n_fail = 0, scnt = 0;
   time        last_stb;

   text_addr_gen dut (
      .pclk(pclk), .reset(reset), .pc_ena(pc_ena),
      .hde(hde), .vde(vde), .hsync(hsync), .vsync(vsync),
      .pix_valid(pix_valid), .char_addr(char_addr), .font_row(font_row), .pix_col(pix_col),
      .frame_start(frame_start), .hde_o(hde_o), .vde_o(vde_o), .hsync_o(hsync_o), .vsync_o(vsync_o)
   );

   initial forever #5 pclk = ~pclk;
   initial forever @(negedge pclk) pc_ena = (pc_ena == 4'd4) ? 4'd0 : pc_ena + 4'd1;

   // Scoreboard: pixel expectations pop on their due strobe; *_o compared against a history of sampled inputs.
   initial begin : mon
      logic       stb, rs;
      logic [3:0] smp, es;
      exp_t       e;
      forever begin
         @(posedge pclk);
         stb = pc_ena == 4'd1;
         rs  = reset;
         smp = {hde, vde, hsync, vsync};
         #1;
         if (rs) begin
            q.delete();
            hist.delete();
         end else if (stb) begin
            scnt++;
            hist.push_back(smp);
            es = hist.size() > 3 ? hist[hist.size()-4] : 4'b0;
            if (hist.size() > 4) void'(hist.pop_front());
            n_chk++;
            if ({hde_o, vde_o, hsync_o, vsync_o} !== es) begin
               n_fail++;
               $display("FAIL sync_o strobe %0d: got %b want %b", scnt, {hde_o, vde_o, hsync_o, vsync_o}, es);
            end
            n_chk++;
            if (q.size() > 0 && q[0].due == scnt) begin
               e = q.pop_front();
               if (pix_valid !== 1'b1 || char_addr !== e.addr || font_row !== e.fr || pix_col !== e.pc || frame_start !== e.fs) begin
                  n_fail++;
                  $display("FAIL pixel x=%0d y=%0d: got valid=%b addr=%0d row=%0d col=%0d fs=%b, want valid=1 addr=%0d row=%0d col=%0d fs=%b",
                           e.x, e.y, pix_valid, char_addr, font_row, pix_col, frame_start, e.addr, e.fr, e.pc, e.fs);
               end
            end else if (pix_valid !== 1'b0 || frame_start !== 1'b0) begin
               n_fail++;
               $display("FAIL idle strobe %0d: got valid=%b fs=%b want 0 0", scnt, pix_valid, frame_start);
            end
         end else begin
            n_chk++;
            if (frame_start !== 1'b0) begin
               n_fail++;
               $display("FAIL frame_start_width: got %b want 0 off-strobe", frame_start);
            end
         end
      end
   end

   task automatic put(input logic h, v, hs, vs);
      {hde, vde, hsync, vsync} = {h, v, hs, vs};
      do @(posedge pclk); while (pc_ena != 4'd1);
      last_stb = $time;
      @(negedge pclk);
   endtask

   task automatic pix(input int x, y, input bit ex, first);
      exp_t e;
      if (ex) begin
         e.due  = scnt + 2;
         e.x    = x;
         e.y    = y;
         e.addr = 13'((y / 16) * 80 + ((x / 8) > 79 ? 79 : x / 8));
         e.fr   = 4'(y % 16);
         e.pc   = 3'(x % 8);
         e.fs   = first;
         q.push_back(e);
      end
      put(1'b1, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic blank();
      put(1'b0, 1'b1, 1'b1, 1'b0);
      put(1'b0, 1'b1, 1'b1, 1'b0);
      put(1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic line(input int y, n, input bit ex, first);
      for (int x = 0; x < n; x++) pix(x, y, ex, first && x == 0);
      blank();
   endtask

   task automatic vblank(input int n);
      for (int i = 0; i < n; i++) put(i == 0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge pclk);
      @(negedge pclk);
      reset = 1'b0;
      n_chk++;
      if ({pix_valid, char_addr, font_row, pix_col, frame_start, hde_o, vde_o, hsync_o, vsync_o} !== 26'd0) begin
         n_fail++;
         $display("FAIL reset_init: got %b want all 0", {pix_valid, char_addr, font_row, pix_col, frame_start, hde_o, vde_o, hsync_o, vsync_o});
      end
      vblank(2);
      for (int x = 0; x < 6; x++) pix(x, 0, 1'b1, x == 0);
      reset = 1'b1;
      repeat (3) @(posedge pclk);
      @(negedge pclk);
      reset = 1'b0;
      n_chk++;
      if ({pix_valid, char_addr, font_row, pix_col, frame_start, hde_o, vde_o, hsync_o, vsync_o} !== 26'd0) begin
         n_fail++;
         $display("FAIL reset_midline: got %b want all 0", {pix_valid, char_addr, font_row, pix_col, frame_start, hde_o, vde_o, hsync_o, vsync_o});
      end
      for (int x = 6; x < 20; x++) pix(x, 0, 1'b0, 1'b0);
      blank();
      line(1, 8, 1'b0, 1'b0);
      vblank(3);
   endtask

   task automatic test_frame();
      for (int y = 0; y < 480; y++)
         line(y, (y == 0 || y == 479) ? 640 : y == 15 ? 700 : y == 16 ? 9 : 1, 1'b1, y == 0);
      vblank(3);
   endtask

   task automatic test_back_to_back();
      for (int f = 0; f < 2; f++) begin
         for (int y = 0; y < 18; y++) begin
            for (int x = 0; x < 3; x++) pix(x, y, 1'b1, y == 0 && x == 0);
            if (y < 17) blank();
         end
         vblank(1);
      end
      vblank(2);
   endtask

   task automatic test_sync_delay();
      time t0, t1;
      bit  found;
      repeat (4) put(1'b0, 1'b0, 1'b0, 1'b0);
      put(1'b0, 1'b0, 1'b1, 1'b0);
      t0    = last_stb;
      t1    = 0;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(posedge pclk);
         #1;
         if (hsync_o) begin
            found = 1'b1;
            t1    = $time - 1;
         end
      end
      @(negedge pclk);
      n_chk++;
      if (!found || t1 - t0 != 150) begin
         n_fail++;
         $display("FAIL hsync_o_delay: got found=%0d delay=%0t want 150", found, t1 - t0);
      end
      repeat (6) put(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_frame();
      test_back_to_back();
      test_sync_delay();
      repeat (4) put(1'b0, 1'b0, 1'b0, 1'b0);
      n_chk++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
